// File: rtl/stripe_arbiter.sv
// stripe_arbiter: round-robin share of one stripe input between A and B.
// Bursts start on lane0 and close on lane1, padding an odd tail.
module stripe_arbiter #(
  parameter int WIDTH = 32,
  parameter int MAX_BURST = 8,
  parameter logic [WIDTH-1:0] PAD_WORD = WIDTH'(32'hBCBCBCBC)
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             valid_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ready_a,
  input  logic             valid_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ready_b,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             grant_a,
  output logic             grant_b,
  output logic [7:0]       pad_cnt
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERV_A = 2'd1,
    SERV_B = 2'd2
  } state_t;

  state_t          state;
  state_t          other;
  logic            rr_last;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic            parity;
  logic            cur_v;
  logic            oth_v;
  logic [WIDTH-1:0] cur_d;
  logic            is_b;

  assign ready_a = (state == SERV_A);
  assign ready_b = (state == SERV_B);
  assign grant_a = ready_a;
  assign grant_b = ready_b;

  assign is_b    = (state == SERV_B);
  assign cur_v   = is_b ? valid_b : valid_a;
  assign cur_d   = is_b ? data_b : data_a;
  assign oth_v   = is_b ? valid_a : valid_b;
  assign other   = is_b ? SERV_A : SERV_B;
  assign cnt_inc = cnt + CW'(1);

  // rr_last: 0 = A served last, 1 = B served last
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      cnt       <= '0;
      parity    <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      pad_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          data_out  <= '0;
          valid_out <= 1'b0;
          if (valid_a && (rr_last || !valid_b))
            state <= SERV_A;
          else if (valid_b)
            state <= SERV_B;
        end
        SERV_A, SERV_B: begin
          if (cur_v) begin
            data_out  <= cur_d;
            valid_out <= 1'b1;
            parity    <= ~parity;
            if (cnt_inc == CW'(MAX_BURST)) begin
              cnt     <= '0;
              rr_last <= is_b;
              state   <= oth_v ? other : IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            // an odd tail leaves lane1 open; close it with a pad
            if (cnt[0]) begin
              data_out  <= PAD_WORD;
              valid_out <= 1'b1;
              parity    <= ~parity;
              if (pad_cnt != 8'hFF)
                pad_cnt <= pad_cnt + 8'd1;
            end else begin
              data_out  <= '0;
              valid_out <= 1'b0;
            end
            cnt     <= '0;
            rr_last <= is_b;
            state   <= oth_v ? other : IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          data_out  <= '0;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stripe_arbiter.sv
// tb_stripe_arbiter: scoreboard bench for stripe_arbiter.
// Expected words are queued with stimulus and matched on valid_out.
module tb_stripe_arbiter;

  localparam logic [31:0] PAD = 32'hBCBCBCBC;

  logic        clk_2f = 1'b0;
  logic        reset;
  logic        valid_a, valid_b;
  logic [31:0] data_a, data_b;
  logic        ready_a, ready_b;
  logic [31:0] data_out;
  logic        valid_out;
  logic        grant_a, grant_b;
  logic [7:0]  pad_cnt;

  stripe_arbiter dut (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .valid_a   (valid_a),
    .data_a    (data_a),
    .ready_a   (ready_a),
    .valid_b   (valid_b),
    .data_b    (data_b),
    .ready_b   (ready_b),
    .data_out  (data_out),
    .valid_out (valid_out),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .pad_cnt   (pad_cnt)
  );

  always #5 clk_2f = ~clk_2f;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [31:0] src_a[$];
  logic [31:0] src_b[$];
  logic [31:0] exp_q[$];
  int          obs_t[$];
  logic        en_a, en_b;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cyc %0d)",
                  tag, got, exp, cyc);
  endtask

  task automatic drive();
    valid_a = en_a && (src_a.size() > 0);
    data_a  = valid_a ? src_a[0] : '0;
    valid_b = en_b && (src_b.size() > 0);
    data_b  = valid_b ? src_b[0] : '0;
  endtask

  task automatic tick();
    logic aa, ab;
    aa = valid_a & ready_a & ~reset;
    ab = valid_b & ready_b & ~reset;
    @(posedge clk_2f);
    #1;
    cyc++;
    if (aa) src_a.delete(0);
    if (ab) src_b.delete(0);
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        chk("unexp_word", data_out, 32'hDEAD_0000);
      end else begin
        chk("data", data_out, exp_q.pop_front());
        obs_t.push_back(cyc);
      end
    end else begin
      chk("idle_zero", data_out, 32'h0);
    end
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    src_a.delete();
    src_b.delete();
    exp_q.delete();
    drive();
    tick();
    tick();
    reset = 1'b0;
    obs_t.delete();
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) chk("timeout", 32'(exp_q.size()), 0);
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    drive();

    // 1: reset held with both requesters valid
    src_a.push_back(32'h1);
    src_b.push_back(32'h2);
    en_a = 1'b1;
    en_b = 1'b1;
    drive();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", 32'(valid_out), 0);
      chk("rst_ready", {30'd0, ready_a, ready_b}, 0);
      chk("rst_grant", {30'd0, grant_a, grant_b}, 0);
      chk("rst_pad", 32'(pad_cnt), 0);
    end

    // 2: A alone, 16 words, burst split by one idle cycle
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      src_a.push_back(32'(i));
      exp_q.push_back(32'(i));
    end
    en_a = 1'b1;
    drive();
    run(60);
    if (obs_t.size() == 16) begin
      chk("t2_back2back", 32'(obs_t[1] - obs_t[0]), 1);
      chk("t2_gap", 32'(obs_t[8] - obs_t[7]), 2);
    end else begin
      chk("t2_count", 32'(obs_t.size()), 16);
    end
    chk("t2_pad", 32'(pad_cnt), 0);

    // 3: both always valid, A first, switch without bubble
    do_reset();
    for (int i = 0; i < 8; i++) begin
      src_a.push_back(32'hA0 + 32'(i));
      src_b.push_back(32'hB0 + 32'(i));
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hA0 + 32'(i));
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hB0 + 32'(i));
    en_a = 1'b1;
    en_b = 1'b1;
    drive();
    run(60);
    if (obs_t.size() == 16)
      chk("t3_no_bubble", 32'(obs_t[8] - obs_t[7]), 1);
    else
      chk("t3_count", 32'(obs_t.size()), 16);

    // 4: odd A burst ends on gap -> pad, then B
    do_reset();
    for (int i = 0; i < 3; i++) src_a.push_back(32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++) src_b.push_back(32'hB0 + 32'(i));
    for (int i = 0; i < 3; i++) exp_q.push_back(32'hA0 + 32'(i));
    exp_q.push_back(PAD);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hB0 + 32'(i));
    en_a = 1'b1;
    en_b = 1'b1;
    drive();
    run(60);
    if (obs_t.size() == 8)
      chk("t4_b_after_pad", 32'(obs_t[4] - obs_t[3]), 1);
    else
      chk("t4_count", 32'(obs_t.size()), 8);
    chk("t4_pad", 32'(pad_cnt), 1);

    // 5: even A burst ends on gap -> no pad, B next
    do_reset();
    for (int i = 0; i < 4; i++) src_a.push_back(32'hA0 + 32'(i));
    for (int i = 0; i < 2; i++) src_b.push_back(32'hB0 + 32'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
    for (int i = 0; i < 2; i++) exp_q.push_back(32'hB0 + 32'(i));
    en_a = 1'b1;
    en_b = 1'b1;
    drive();
    run(60);
    if (obs_t.size() == 6)
      chk("t5_b_slot", 32'(obs_t[4] - obs_t[3]), 2);
    else
      chk("t5_count", 32'(obs_t.size()), 6);
    chk("t5_pad", 32'(pad_cnt), 0);

    // 6: reset mid-burst drops the half pair, A wins again
    do_reset();
    for (int i = 0; i < 11; i++) src_a.push_back(32'h60 + 32'(i));
    for (int i = 0; i < 2; i++) src_b.push_back(32'h70 + 32'(i));
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h60 + 32'(i));
    en_a = 1'b1;
    en_b = 1'b1;
    drive();
    begin
      int n = 0;
      while (obs_t.size() < 3 && n < 20) begin
        tick();
        n++;
      end
    end
    chk("t6_pre", 32'(obs_t.size()), 3);
    reset = 1'b1;
    tick();
    chk("t6_rst_valid", 32'(valid_out), 0);
    chk("t6_rst_grant", {30'd0, grant_a, grant_b}, 0);
    chk("t6_rst_pad", 32'(pad_cnt), 0);
    reset = 1'b0;
    for (int i = 3; i < 11; i++) exp_q.push_back(32'h60 + 32'(i));
    for (int i = 0; i < 2; i++) exp_q.push_back(32'h70 + 32'(i));
    run(60);
    chk("t6_pad", 32'(pad_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
